interleave_frame_ctrl: RTL and testbench

- Frame sequencer placed in front of and behind the 128-bit interleaver block.
- Collects serial encoded bits from the convolutional encoder into one frame register.
- Fires the interleaver with a one-cycle valid pulse and captures its permuted frame.
- Streams the result out as OUT_W-bit words over a valid/ready handshake to the modulator.

---
 rtl/interleave_frame_ctrl.sv | 140 ++++++++++++++
 tb/tb_interleave_frame_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/interleave_frame_ctrl.sv
// rtl/interleave_frame_ctrl.sv - frame sequencer around the interleaver: serial fill, fire, capture, word drain
module interleave_frame_ctrl #(
    parameter int FRAME_W = 128,
    parameter int OUT_W   = 8,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_bit,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    output logic [FRAME_W-1:0] il_data_in,
    output logic               il_valid_in,
    input  logic [FRAME_W-1:0] il_data_out,
    input  logic               il_valid_out,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic [CNT_W-1:0]   frame_count,
    output logic               err_timeout,
    input  logic               err_clr,
    output logic               busy
);

    localparam int WORDS = FRAME_W / OUT_W;
    localparam int BC_W  = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam int WT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int WD_W  = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(FRAME_W - 1);
    localparam logic [WT_W-1:0] WAIT_LAST = WT_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WORD_LAST = WD_W'(WORDS - 1);

    typedef enum logic [1:0] {
        S_FILL,
        S_FIRE,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t             state;
    state_t             state_d;
    logic [BC_W-1:0]    bit_cnt;
    logic [WT_W-1:0]    wait_cnt;
    logic [WD_W-1:0]    word_cnt;
    logic [FRAME_W-1:0] frame_q;
    logic [FRAME_W-1:0] cap_q;

    logic accept;
    logic timeout_evt;
    logic last_hs;

    // A flush in the same cycle as a valid bit drops the bit.
    assign accept      = (state == S_FILL) && in_valid && !flush;
    assign timeout_evt = (state == S_WAIT) && !il_valid_out && (wait_cnt == WAIT_LAST);
    assign last_hs     = (state == S_DRAIN) && out_ready && (word_cnt == WORD_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FILL;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            S_FILL:  if (accept && (bit_cnt == BIT_LAST)) state_d = S_FIRE;
            S_FIRE:  state_d = S_WAIT;
            S_WAIT: begin
                if (il_valid_out)     state_d = S_DRAIN;
                else if (timeout_evt) state_d = S_FILL;
            end
            S_DRAIN: if (last_hs) state_d = S_FILL;
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt     <= '0;
            wait_cnt    <= '0;
            word_cnt    <= '0;
            frame_q     <= '0;
            cap_q       <= '0;
            frame_count <= '0;
        end else begin
            case (state)
                S_FILL: begin
                    if (flush) begin
                        bit_cnt <= '0;
                    end else if (in_valid) begin
                        frame_q[bit_cnt] <= in_bit;
                        bit_cnt          <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
                    end
                end
                S_FIRE: wait_cnt <= '0;
                S_WAIT: begin
                    if (il_valid_out) begin
                        cap_q    <= il_data_out;
                        word_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        word_cnt <= (word_cnt == WORD_LAST) ? '0 : word_cnt + 1'b1;
                        if (word_cnt == WORD_LAST) frame_count <= frame_count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // A new timeout outranks a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_timeout <= 1'b0;
        end else if (timeout_evt) begin
            err_timeout <= 1'b1;
        end else if (err_clr) begin
            err_timeout <= 1'b0;
        end
    end

    assign in_ready    = (state == S_FILL);
    assign il_valid_in = (state == S_FIRE);
    assign il_data_in  = frame_q;
    assign out_valid   = (state == S_DRAIN);
    assign out_last    = (state == S_DRAIN) && (word_cnt == WORD_LAST);
    assign out_data    = (state == S_DRAIN) ? cap_q[int'(word_cnt) * OUT_W +: OUT_W] : '0;
    assign busy        = (state != S_FILL);

endmodule

// File: tb/tb_interleave_frame_ctrl.sv
// tb/tb_interleave_frame_ctrl.sv - scoreboard bench for interleave_frame_ctrl with a bit-reversing model interleaver
module tb_interleave_frame_ctrl;

    localparam int FW = 128;
    localparam int OW = 8;
    localparam int TO = 16;
    localparam int CW = 2;
    localparam int NW = FW / OW;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_bit;
    logic          in_valid;
    logic          in_ready;
    logic          flush;
    logic [FW-1:0] il_data_in;
    logic          il_valid_in;
    logic [FW-1:0] il_data_out = '0;
    logic          il_valid_out = 1'b0;
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic [CW-1:0] frame_count;
    logic          err_timeout;
    logic          err_clr;
    logic          busy;

    always #5 clk = ~clk;

    interleave_frame_ctrl #(
        .FRAME_W(FW), .OUT_W(OW), .TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .il_data_in(il_data_in), .il_valid_in(il_valid_in),
        .il_data_out(il_data_out), .il_valid_out(il_valid_out),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .frame_count(frame_count), .err_timeout(err_timeout), .err_clr(err_clr), .busy(busy)
    );

    function automatic logic [FW-1:0] perm(input logic [FW-1:0] x);
        logic [FW-1:0] r;
        for (int i = 0; i < FW; i++) r[i] = x[FW-1-i];
        return r;
    endfunction

    // Model interleaver: answers in the cycle after the start pulse when enabled.
    logic il_en = 1'b1;
    logic fire_seen = 1'b0;
    always @(negedge clk) begin
        il_valid_out = fire_seen;
        il_data_out  = perm(il_data_in);
        fire_seen    = il_en && il_valid_in;
    end

    int         checks = 0;
    int         errors = 0;
    int         exp_cnt = 0;
    logic [8:0] sb[$];

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [FW-1:0] d, input bit resp);
        logic [FW-1:0] p;
        for (int k = 0; k < FW; k++) begin
            in_bit   = d[k];
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_bit   = 1'b0;
        chk("fire_pulse", il_valid_in, 1);
        chk("il_data_in", il_data_in, d);
        chk("in_ready_fire", in_ready, 0);
        chk("busy_fire", busy, 1);
        if (resp) begin
            p = perm(d);
            for (int n = 0; n < NW; n++) sb.push_back({n == NW - 1, p[n*OW +: OW]});
        end
        @(negedge clk);
        chk("fire_once", il_valid_in, 0);
        chk("in_ready_wait", in_ready, 0);
    endtask

    task automatic drain(input int mode, input int max_words);
        int         got = 0;
        int         cyc = 0;
        int         stall = 0;
        bit         tog = 1'b0;
        bit         prev_stall = 1'b0;
        bit         rdy;
        logic [OW-1:0] prev_d = '0;
        logic       prev_l = 1'b0;
        logic [8:0] e;
        while (got < max_words && cyc < 300) begin
            rdy = 1'b1;
            if (mode == 1 && got >= 3) begin
                if (got == 3 && stall < 5) begin
                    rdy = 1'b0;
                    stall++;
                end else begin
                    rdy = tog;
                    tog = !tog;
                end
            end
            if (out_valid) begin
                if (prev_stall) begin
                    chk("stall_data", out_data, prev_d);
                    chk("stall_last", out_last, prev_l);
                end
                chk("in_ready_drain", in_ready, 0);
                if (rdy) begin
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("word_data", out_data, e[7:0]);
                        chk("word_last", out_last, e[8]);
                    end else begin
                        chk("unexpected_word", out_valid, 0);
                    end
                    got++;
                end
                prev_stall = !rdy;
                prev_d     = out_data;
                prev_l     = out_last;
            end else begin
                rdy = 1'b0;
            end
            out_ready = rdy;
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        chk("drain_in_time", cyc < 300, 1);
    endtask

    task automatic end_frame();
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        chk("frame_count", frame_count, exp_cnt);
        chk("in_ready_after", in_ready, 1);
        chk("busy_after", busy, 0);
        chk("out_valid_after", out_valid, 0);
        chk("sb_drained", sb.size(), 0);
    endtask

    task automatic timeout_run(input bit clr_same);
        il_en = 1'b0;
        send_frame({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        for (int w = 1; w < TO; w++) begin
            chk("no_out_valid", out_valid, 0);
            @(negedge clk);
        end
        chk("err_before_timeout", err_timeout, 0);
        chk("busy_last_wait", busy, 1);
        err_clr = clr_same;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_timeout_set", err_timeout, 1);
        chk("in_ready_timeout", in_ready, 1);
        chk("busy_timeout", busy, 0);
        chk("count_timeout", frame_count, exp_cnt);
        il_en = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FW-1:0] d;
        reset = 1'b1; in_bit = 0; in_valid = 0; flush = 0; out_ready = 0; err_clr = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        chk("idle_out_valid", out_valid, 0);
        chk("idle_il_valid_in", il_valid_in, 0);
        chk("idle_frame_count", frame_count, 0);
        chk("idle_busy", busy, 0);
        chk("idle_err", err_timeout, 0);

        for (int k = 0; k < FW; k++) d[k] = k[0];
        send_frame(d, 1'b1);
        chk("pattern_aa", il_data_in, {(FW/8){8'hAA}});
        drain(0, NW);
        end_frame();

        send_frame({$urandom, $urandom, $urandom, $urandom}, 1'b1);
        drain(1, NW);
        end_frame();

        timeout_run(1'b0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_cleared", err_timeout, 0);
        timeout_run(1'b1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_cleared_again", err_timeout, 0);

        for (int k = 0; k < 50; k++) begin
            in_bit = 1'($urandom); in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int k = 0; k < 20; k++) begin
            in_bit = 1'b0; in_valid = 1'b1;
            @(negedge clk);
        end
        in_bit = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        send_frame('1, 1'b1);
        drain(0, NW);
        end_frame();

        send_frame({$urandom, $urandom, $urandom, $urandom}, 1'b1);
        drain(0, 7);
        chk("drain_word7_valid", out_valid, 1);
        reset = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_il_valid_in", il_valid_in, 0);
        chk("rst_il_data_in", il_data_in, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_err", err_timeout, 0);
        sb.delete();
        exp_cnt = 0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int f = 0; f < 5; f++) begin
            send_frame({$urandom, $urandom, $urandom, $urandom}, 1'b1);
            drain(0, NW);
            end_frame();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
